// File: rtl/huff_emit_sequencer_pkg.sv
// Shared types and constants for the Huffman emit sequencer:
// FSM state enum, held-token struct and field widths.
package huff_pkg;

  localparam int HCODE_W   = 16;
  localparam int AMP_W     = 11;
  localparam int BYTE_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    HUFF,
    AMP,
    PAD,
    FLUSH,
    DONE
  } state_e;

  typedef struct packed {
    logic [HCODE_W-1:0] hcode;
    logic [4:0]         hlen;
    logic [AMP_W-1:0]   amp;
    logic [3:0]         asize;
    logic               eoi;
  } tok_t;

endpackage

// File: rtl/huff_emit_sequencer_if.sv
// Token input and code_shifter output bus of the Huffman emit sequencer.
// Token handshake: a token transfers on a clk edge where tok_valid && tok_ready;
// the producer holds its fields stable while tok_valid is high and not yet accepted.
// Shifter side: a beat is consumed on every edge with sh_ena=1, which is only
// ever asserted together with sh_rdy; sh_flush is a level held until sh_rdy.
interface huff_emit_sequencer_if #(
  parameter int WIDTH   = 32,
  parameter int HCODE_W = 16,
  parameter int AMP_W   = 11
);
  localparam int SZ_W = $clog2(WIDTH) + 1;

  logic               tok_valid;
  logic               tok_ready;
  logic [HCODE_W-1:0] tok_hcode;
  logic [4:0]         tok_hlen;
  logic [AMP_W-1:0]   tok_amp;
  logic [3:0]         tok_asize;
  logic               tok_eoi;
  logic               sh_rdy;
  logic               sh_ena;
  logic [WIDTH-1:0]   sh_code;
  logic [SZ_W-1:0]    sh_size;
  logic               sh_flush;
  logic               done;

  modport master (
    output tok_valid, tok_hcode, tok_hlen, tok_amp, tok_asize, tok_eoi, sh_rdy,
    input  tok_ready, sh_ena, sh_code, sh_size, sh_flush, done
  );

  modport slave (
    input  tok_valid, tok_hcode, tok_hlen, tok_amp, tok_asize, tok_eoi, sh_rdy,
    output tok_ready, sh_ena, sh_code, sh_size, sh_flush, done
  );

endinterface

// File: rtl/huff_emit_sequencer.sv
// Splits Huffman code + amplitude tokens into size-qualified code_shifter beats,
// byte-pads with 1s and flushes at end of image. Define HUFF_AMP_MERGE_EN to fuse code+amplitude into one beat.
module huff_emit_sequencer #(
  parameter int WIDTH   = 32,
  parameter int HCODE_W = 16,
  parameter int AMP_W   = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  huff_emit_sequencer_if.slave  bus,
  output huff_pkg::state_e      dbg_state,
  output logic [2:0]            dbg_bitpos,
  output huff_pkg::tok_t        dbg_tok
);
  import huff_pkg::*;

  localparam int SZ_W = $clog2(WIDTH) + 1;

  state_e            state;
  state_e            next_state;
  tok_t              tok;
  logic [2:0]        bitpos;
  logic              tok_ready_q;
  logic              flush_q;
  logic              done_q;
  logic              accept;
  logic              emitting;
  logic              sh_ena;
  logic [WIDTH-1:0]  code;
  logic [SZ_W-1:0]   size;

  assign accept = bus.tok_valid && tok_ready_q;

  always_comb begin
    code       = '0;
    size       = '0;
    emitting   = 1'b0;
    next_state = state;
    case (state)
      HUFF: begin
        emitting = 1'b1;
`ifdef HUFF_AMP_MERGE_EN
        if (tok.asize != 4'd0) begin
          code = (WIDTH'(tok.hcode) << tok.asize) | WIDTH'(tok.amp);
          size = SZ_W'(tok.hlen) + SZ_W'(tok.asize);
        end else begin
          code = WIDTH'(tok.hcode);
          size = SZ_W'(tok.hlen);
        end
`else
        code = WIDTH'(tok.hcode);
        size = SZ_W'(tok.hlen);
`endif
      end
      AMP: begin
        emitting = 1'b1;
        code     = WIDTH'(tok.amp);
        size     = SZ_W'(tok.asize);
      end
      PAD: begin
        // Top up the current byte with 1s; an aligned stream needs no beat.
        if (bitpos != 3'd0) begin
          emitting = 1'b1;
          code     = WIDTH'(8'hFF >> bitpos);
          size     = SZ_W'(BYTE_BITS - int'(bitpos));
        end
      end
      default: ;
    endcase

    // The shifter counts a beat on ena alone, so ena must be gated by rdy.
    sh_ena = emitting && bus.sh_rdy;

    case (state)
      IDLE: begin
        if (accept) begin
          if (bus.tok_eoi)                next_state = PAD;
          else if (bus.tok_hlen != 5'd0)  next_state = HUFF;
          else if (bus.tok_asize != 4'd0) next_state = AMP;
          else                            next_state = IDLE;
        end
      end
      HUFF: begin
        if (sh_ena) begin
`ifdef HUFF_AMP_MERGE_EN
          next_state = IDLE;
`else
          next_state = (tok.asize != 4'd0) ? AMP : IDLE;
`endif
        end
      end
      AMP:     if (sh_ena) next_state = IDLE;
      PAD:     if (bitpos == 3'd0 || sh_ena) next_state = FLUSH;
      FLUSH:   if (bus.sh_rdy) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      tok         <= '0;
      bitpos      <= 3'd0;
      tok_ready_q <= 1'b0;
      flush_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state       <= next_state;
      tok_ready_q <= (next_state == IDLE);
      flush_q     <= (next_state == FLUSH);
      done_q      <= (next_state == DONE);
      if (accept) begin
        tok.hcode <= bus.tok_hcode[HCODE_W-1:0];
        tok.hlen  <= bus.tok_hlen;
        tok.amp   <= bus.tok_amp[AMP_W-1:0];
        tok.asize <= bus.tok_asize;
        tok.eoi   <= bus.tok_eoi;
      end
      if (sh_ena)
        bitpos <= bitpos + size[2:0];
      else if (state == DONE)
        bitpos <= 3'd0;
    end
  end

  assign bus.tok_ready = tok_ready_q;
  assign bus.sh_ena    = sh_ena;
  assign bus.sh_code   = code;
  assign bus.sh_size   = size;
  assign bus.sh_flush  = flush_q;
  assign bus.done      = done_q;

  assign dbg_state  = state;
  assign dbg_bitpos = bitpos;
  assign dbg_tok    = tok;

endmodule

// File: tb/tb_huff_emit_sequencer.sv
// Bench for huff_emit_sequencer: directed corner cases, then random images
// whose emitted bitstream is compared byte-by-byte against a token-level model.
module tb_huff_emit_sequencer;
  import huff_pkg::*;

  localparam int WIDTH = 32;
  localparam int SZ_W  = $clog2(WIDTH) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  huff_emit_sequencer_if #(.WIDTH(WIDTH), .HCODE_W(16), .AMP_W(11)) bus ();

  state_e     dbg_state;
  logic [2:0] dbg_bitpos;
  tok_t       dbg_tok;

  huff_emit_sequencer #(.WIDTH(WIDTH), .HCODE_W(16), .AMP_W(11)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .dbg_state  (dbg_state),
    .dbg_bitpos (dbg_bitpos),
    .dbg_tok    (dbg_tok)
  );

  // ---------------- clock / reset / ready driver ----------------
  always #5 clk = ~clk;

  bit   rdy_auto  = 1'b0;
  logic rdy_force = 1'b1;

  initial begin
    bus.sh_rdy    = 1'b1;
    bus.tok_valid = 1'b0;
    bus.tok_hcode = '0;
    bus.tok_hlen  = '0;
    bus.tok_amp   = '0;
    bus.tok_asize = '0;
    bus.tok_eoi   = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      bus.sh_rdy = rdy_auto ? ($urandom_range(0, 3) != 0) : rdy_force;
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic                  exp_bits[$];
  logic                  got_bits[$];
  logic [7:0]            exp_q[$];
  logic [SZ_W+WIDTH-1:0] beat_q[$];
  int cyc = 0, flush_cnt = 0, done_cnt = 0, flush_cyc = 0, done_cyc = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (bus.sh_ena) begin
        check("ena_needs_rdy", bus.sh_rdy, 1'b1);
        check("ena_no_flush", bus.sh_flush, 1'b0);
        beat_q.push_back({bus.sh_size, bus.sh_code});
        for (int i = int'(bus.sh_size) - 1; i >= 0; i--) got_bits.push_back(bus.sh_code[i]);
      end
      if (bus.sh_flush) begin
        flush_cnt++;
        flush_cyc = cyc;
      end
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // Reference: a token contributes its code bits then its amplitude bits, MSB first;
  // end of image appends 1s up to the next byte boundary.
  task automatic model_tok(input logic [15:0] hc, input logic [4:0] hl,
                           input logic [10:0] am, input logic [3:0] as, input logic eoi);
    if (eoi) begin
      int pad = (8 - (exp_bits.size() % 8)) % 8;
      repeat (pad) exp_bits.push_back(1'b1);
    end else begin
      for (int i = int'(hl) - 1; i >= 0; i--) exp_bits.push_back(hc[i]);
      for (int i = int'(as) - 1; i >= 0; i--) exp_bits.push_back(am[i]);
    end
  endtask

  function automatic logic [7:0] got_byte(input int k);
    logic [7:0] b = '0;
    for (int j = 0; j < 8; j++) b = {b[6:0], got_bits[8*k+j]};
    return b;
  endfunction

  task automatic check_image();
    logic [7:0] b;
    int nbytes;
    check("img_bits", got_bits.size(), exp_bits.size());
    check("img_aligned", got_bits.size() % 8, 0);
    exp_q = {};
    for (int i = 0; i + 8 <= exp_bits.size(); i += 8) begin
      b = '0;
      for (int j = 0; j < 8; j++) b = {b[6:0], exp_bits[i+j]};
      exp_q.push_back(b);
    end
    nbytes = got_bits.size() / 8;
    for (int k = 0; k < nbytes && exp_q.size() > 0; k++) check("img_byte", got_byte(k), exp_q.pop_front());
  endtask

  task automatic clear_stream();
    exp_bits = {};
    got_bits = {};
    beat_q   = {};
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_tok(input logic [15:0] hc, input logic [4:0] hl,
                          input logic [10:0] am, input logic [3:0] as, input logic eoi);
    bit acc = 1'b0;
    bus.tok_hcode = hc;
    bus.tok_hlen  = hl;
    bus.tok_amp   = am;
    bus.tok_asize = as;
    bus.tok_eoi   = eoi;
    bus.tok_valid = 1'b1;
    for (int i = 0; i < 300 && !acc; i++) begin
      @(negedge clk);
      if (bus.tok_ready) acc = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.tok_valid = 1'b0;
    check("tok_accept", acc, 1'b1);
    if (acc) model_tok(hc, hl, am, as, eoi);
  endtask

  task automatic wait_done();
    int start = done_cnt;
    bit seen  = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (done_cnt != start) seen = 1'b1;
    end
    check("done_seen", seen, 1'b1);
    if (seen) begin
      @(negedge clk);
      check("done_one_cycle", bus.done, 1'b0);
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0;
    rst = 1'b1;
    idle(3);
    @(negedge clk);
    check("rst_state", dbg_state, IDLE);
    check("rst_bitpos", dbg_bitpos, 3'd0);
    check("rst_tok", dbg_tok, '0);
    check("rst_ena", bus.sh_ena, 1'b0);
    check("rst_flush", bus.sh_flush, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_tok_ready", bus.tok_ready, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_stream();

    // code 10 + amplitude 101
    send_tok(16'b10, 5'd2, 11'b101, 4'd3, 1'b0);
    idle(3);
`ifdef HUFF_AMP_MERGE_EN
    check("merge_beats", beat_q.size(), 1);
    if (beat_q.size() >= 1) check("merge_beat0", beat_q[0], {6'd5, 32'b10101});
`else
    check("split_beats", beat_q.size(), 2);
    if (beat_q.size() >= 2) begin
      check("split_beat0", beat_q[0], {6'd2, 32'b10});
      check("split_beat1", beat_q[1], {6'd3, 32'b101});
    end
`endif
    check("bitpos_5", dbg_bitpos, 3'd5);

    // empty token: accepted, nothing emitted
    beat_q = {};
    send_tok(16'h0, 5'd0, 11'h0, 4'd0, 1'b0);
    idle(3);
    check("null_no_beat", beat_q.size(), 0);
    check("null_bitpos", dbg_bitpos, 3'd5);

    // eoi at bitpos 5: pad with three 1s
    beat_q = {};
    f0 = flush_cnt;
    send_tok(16'h0, 5'd0, 11'h0, 4'd0, 1'b1);
    wait_done();
    check("pad_beats", beat_q.size(), 1);
    if (beat_q.size() >= 1) check("pad_beat", beat_q[0], {6'd3, 32'b111});
    check("pad_flush_cycles", flush_cnt - f0, 1);
    check("pad_first_byte", (got_bits.size() >= 8) ? got_byte(0) : 8'h00, 8'b10101111);
    check("done_bitpos", dbg_bitpos, 3'd0);
    check_image();

    // eoi at bitpos 0: flush only
    clear_stream();
    f0 = flush_cnt;
    send_tok(16'h0, 5'd0, 11'h0, 4'd0, 1'b1);
    wait_done();
    check("aligned_no_beat", beat_q.size(), 0);
    check("aligned_flush_cycles", flush_cnt - f0, 1);
    check("aligned_done_after_flush", done_cyc - flush_cyc, 1);

    // stall for 4 cycles in HUFF
    clear_stream();
    rdy_force = 1'b0;
    idle(2);
    send_tok(16'b110, 5'd3, 11'h0, 4'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_state", dbg_state, HUFF);
      check("stall_ena", bus.sh_ena, 1'b0);
      check("stall_code", bus.sh_code, 32'b110);
      check("stall_size", bus.sh_size, 6'd3);
    end
    @(posedge clk);
    #1;
    rdy_force = 1'b1;
    @(negedge clk);
    check("stall_release_ena", bus.sh_ena, 1'b1);
    idle(3);
    check("stall_beats", beat_q.size(), 1);
    if (beat_q.size() >= 1) check("stall_beat", beat_q[0], {6'd3, 32'b110});
    check("stall_bitpos", dbg_bitpos, 3'd3);

    // reset while stalled in AMP
    rdy_force = 1'b0;
    idle(2);
    send_tok(16'h0, 5'd0, 11'b101, 4'd3, 1'b0);
    @(negedge clk);
    check("amp_state", dbg_state, AMP);
    @(posedge clk);
    #1;
    rst = 1'b1;
    rdy_force = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_state", dbg_state, IDLE);
    check("midrst_ena", bus.sh_ena, 1'b0);
    check("midrst_bitpos", dbg_bitpos, 3'd0);
    @(posedge clk);
    #1;
    clear_stream();
    send_tok(16'h0, 5'd1, 11'h0, 4'd0, 1'b0);
    send_tok(16'h0, 5'd0, 11'h0, 4'd0, 1'b1);
    wait_done();
    if (beat_q.size() >= 2) begin
      check("midrst_beat0", beat_q[0], {6'd1, 32'd0});
      check("midrst_pad", beat_q[1], {6'd7, 32'h7F});
    end else begin
      check("midrst_beats", beat_q.size(), 2);
    end
    check_image();

    // random images with random downstream stalls
    rdy_auto = 1'b1;
    for (int img = 0; img < 8; img++) begin
      int ntok = $urandom_range(3, 25);
      clear_stream();
      for (int t = 0; t < ntok; t++) begin
        logic [4:0]  hl;
        logic [3:0]  as;
        logic [15:0] hc;
        logic [10:0] am;
        hl = 5'($urandom_range(0, 16));
        as = 4'($urandom_range(0, 11));
        if ($urandom_range(0, 7) == 0) begin
          hl = 5'd0;
          as = 4'd0;
        end
        hc = 16'($urandom) & 16'((32'd1 << hl) - 1);
        am = 11'($urandom) & 11'((32'd1 << as) - 1);
        send_tok(hc, hl, am, as, 1'b0);
        idle($urandom_range(0, 2));
      end
      send_tok(16'h0, 5'd0, 11'h0, 4'd0, 1'b1);
      wait_done();
      check("img_end_bitpos", dbg_bitpos, 3'd0);
      check_image();
    end
    rdy_auto = 1'b0;
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
